// File: rtl/dram_queue_sched.sv
// Per-queue circular block pointers and DRAM block-command arbiter for the output queues.
// Optional command watchdog: define DRAM_QUEUE_SCHED_TIMEOUT_EN.
module dram_queue_sched #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int QID_WIDTH         = 3,
  parameter int ADDR_WIDTH        = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_OUTPUT_QUEUES-1:0]            wr_req_i,
  input  logic [NUM_OUTPUT_QUEUES-1:0]            rd_req_i,
  input  logic [ADDR_WIDTH*NUM_OUTPUT_QUEUES-1:0] block_addr_lo_i,
  input  logic [ADDR_WIDTH*NUM_OUTPUT_QUEUES-1:0] block_addr_hi_i,
  input  logic [ADDR_WIDTH*NUM_OUTPUT_QUEUES-1:0] ctrl_i,
  output logic                                    cmd_valid_o,
  input  logic                                    cmd_ready_i,
  output logic                                    cmd_rd_wr_L_o,
  output logic [ADDR_WIDTH-1:0]                   cmd_addr_o,
  output logic [QID_WIDTH-1:0]                    cmd_qid_o,
  input  logic                                    cmd_done_i,
  output logic [ADDR_WIDTH*NUM_OUTPUT_QUEUES-1:0] rd_addr_o,
  output logic [ADDR_WIDTH*NUM_OUTPUT_QUEUES-1:0] wr_addr_o,
  output logic [NUM_OUTPUT_QUEUES-1:0]            dram_wr_grant_o,
  output logic [NUM_OUTPUT_QUEUES-1:0]            dram_rd_grant_o,
  output logic                                    sched_err_o
);

  localparam int N  = NUM_OUTPUT_QUEUES;
  localparam int AW = ADDR_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_SANITIZE, S_ARB, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         lo [N];
  logic [AW-1:0]         hi [N];
  logic [AW:0]           cap [N];
  logic [N-1:0]          en, flush, wr_elig, rd_elig;
  logic [AW-1:0]         rd_ptr_q [N];
  logic [AW-1:0]         wr_ptr_q [N];
  logic [AW-1:0]         occ_q [N];
  logic [QID_WIDTH-1:0]  wr_rr_q, rd_rr_q, sel_qid_q, arb_qid;
  logic [QID_WIDTH:0]    wr_pick, rd_pick;
  logic                  last_rd_q, sel_rd_q, choose_rd, tmo_hit, done_fire;
  logic [AW-1:0]         sel_addr_q, served_ptr, next_ptr;
  logic [N-1:0]          wr_grant_q, rd_grant_q;
  logic                  unused_ctrl;

  assign unused_ctrl = ^ctrl_i;

  // Returns {found, qid}: first eligible queue searching upward from ptr+1, wrapping.
  function automatic logic [QID_WIDTH:0] rr_pick(input logic [N-1:0] elig,
                                                 input logic [QID_WIDTH-1:0] ptr);
    logic [QID_WIDTH-1:0] idx;
    rr_pick = '0;
    for (int i = N; i >= 1; i--) begin
      idx = ptr + QID_WIDTH'(i);
      if (elig[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred.
  always_comb begin
    for (int q = 0; q < N; q++) begin
      lo[q]      = block_addr_lo_i[q*AW +: AW];
      hi[q]      = block_addr_hi_i[q*AW +: AW];
      en[q]      = ctrl_i[q*AW];
      flush[q]   = ctrl_i[q*AW + 1];
      cap[q]     = {1'b0, hi[q]} - {1'b0, lo[q]} + 1'b1;
      wr_elig[q] = en[q] & wr_req_i[q] & (lo[q] <= hi[q]) & ({1'b0, occ_q[q]} < cap[q]);
      rd_elig[q] = en[q] & rd_req_i[q] & (occ_q[q] != '0);
      rd_addr_o[q*AW +: AW] = rd_ptr_q[q];
      wr_addr_o[q*AW +: AW] = wr_ptr_q[q];
    end
  end

  always_comb begin
    wr_pick    = rr_pick(wr_elig, wr_rr_q);
    rd_pick    = rr_pick(rd_elig, rd_rr_q);
    // Reads win right after a write; otherwise writes have priority.
    choose_rd  = (|rd_elig) & (~last_rd_q | ~(|wr_elig));
    arb_qid    = choose_rd ? rd_pick[QID_WIDTH-1:0] : wr_pick[QID_WIDTH-1:0];
    served_ptr = sel_rd_q ? rd_ptr_q[sel_qid_q] : wr_ptr_q[sel_qid_q];
    next_ptr   = (served_ptr == hi[sel_qid_q]) ? lo[sel_qid_q] : served_ptr + 1'b1;
    done_fire  = (state_q == S_WAIT) & cmd_done_i & ~tmo_hit;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_SANITIZE;
      S_SANITIZE: state_d = S_ARB;
      S_ARB:      if ((|wr_elig) | (|rd_elig)) state_d = S_ISSUE;
      S_ISSUE:    if (cmd_ready_i) state_d = S_WAIT;
      S_WAIT:     if (cmd_done_i) state_d = S_DONE;
      S_DONE:     state_d = S_SANITIZE;
      default:    state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_IDLE;
  end

  // Output logic
  always_comb begin
    cmd_valid_o     = (state_q == S_ISSUE);
    cmd_rd_wr_L_o   = sel_rd_q;
    cmd_addr_o      = sel_addr_q;
    cmd_qid_o       = sel_qid_q;
    dram_wr_grant_o = wr_grant_q;
    dram_rd_grant_o = rd_grant_q;
  end

  // NOTE: the pointer/occupancy arrays are architectural state, so they are reset like any register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < N; q++) begin
        rd_ptr_q[q] <= '0;
        wr_ptr_q[q] <= '0;
        occ_q[q]    <= '0;
      end
      wr_rr_q    <= '0;
      rd_rr_q    <= '0;
      last_rd_q  <= 1'b1;
      sel_rd_q   <= 1'b0;
      sel_qid_q  <= '0;
      sel_addr_q <= '0;
      wr_grant_q <= '0;
      rd_grant_q <= '0;
    end else begin
      wr_grant_q <= '0;
      rd_grant_q <= '0;
      if (state_q == S_SANITIZE) begin
        for (int q = 0; q < N; q++) begin
          if (flush[q] || (lo[q] > hi[q]) ||
              (rd_ptr_q[q] < lo[q]) || (rd_ptr_q[q] > hi[q]) ||
              (wr_ptr_q[q] < lo[q]) || (wr_ptr_q[q] > hi[q])) begin
            rd_ptr_q[q] <= lo[q];
            wr_ptr_q[q] <= lo[q];
            occ_q[q]    <= '0;
          end
        end
      end
      if (state_q == S_ARB && state_d == S_ISSUE) begin
        sel_rd_q   <= choose_rd;
        sel_qid_q  <= arb_qid;
        sel_addr_q <= choose_rd ? rd_ptr_q[arb_qid] : wr_ptr_q[arb_qid];
      end
      if (done_fire) begin
        last_rd_q <= sel_rd_q;
        if (sel_rd_q) begin
          rd_ptr_q[sel_qid_q]   <= next_ptr;
          occ_q[sel_qid_q]      <= occ_q[sel_qid_q] - 1'b1;
          rd_grant_q[sel_qid_q] <= 1'b1;
          rd_rr_q               <= sel_qid_q;
        end else begin
          wr_ptr_q[sel_qid_q]   <= next_ptr;
          occ_q[sel_qid_q]      <= occ_q[sel_qid_q] + 1'b1;
          wr_grant_q[sel_qid_q] <= 1'b1;
          wr_rr_q               <= sel_qid_q;
        end
      end
    end
  end

`ifdef DRAM_QUEUE_SCHED_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        err_q;

  assign tmo_hit     = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (tmo_q == 16'hFFFF);
  assign sched_err_o = err_q;

  // Counter restarts on every state change so ISSUE and WAIT each get a full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (state_d != state_q)                              tmo_q <= '0;
      else if (state_q == S_ISSUE || state_q == S_WAIT)    tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign sched_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dram_queue_sched.sv
// Directed bench for dram_queue_sched: write fill/wrap, read/write alternation, round-robin,
// command hold under backpressure, flush, and single-block windows.
module tb_dram_queue_sched;

  localparam int N  = 8;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    wr_req, rd_req;
  logic [AW*N-1:0] lo, hi, ctrl;
  logic            cmd_valid, cmd_ready, cmd_rd_wr_L, cmd_done;
  logic [AW-1:0]   cmd_addr;
  logic [2:0]      cmd_qid;
  logic [AW*N-1:0] rd_addr, wr_addr;
  logic [N-1:0]    wr_grant, rd_grant;
  logic            sched_err;

  int vectors     = 0;
  int miscompares = 0;

  dram_queue_sched dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_req_i        (wr_req),
    .rd_req_i        (rd_req),
    .block_addr_lo_i (lo),
    .block_addr_hi_i (hi),
    .ctrl_i          (ctrl),
    .cmd_valid_o     (cmd_valid),
    .cmd_ready_i     (cmd_ready),
    .cmd_rd_wr_L_o   (cmd_rd_wr_L),
    .cmd_addr_o      (cmd_addr),
    .cmd_qid_o       (cmd_qid),
    .cmd_done_i      (cmd_done),
    .rd_addr_o       (rd_addr),
    .wr_addr_o       (wr_addr),
    .dram_wr_grant_o (wr_grant),
    .dram_rd_grant_o (rd_grant),
    .sched_err_o     (sched_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Serve one command with immediate ready/done and check it plus its grant pulse.
  task automatic serve(input string tag, input bit exp_rd, input int exp_q, input logic [31:0] exp_addr);
    logic [N-1:0] mask;
    mask = N'(1) << exp_q;
    wait_valid();
    check({tag, " valid"}, 32'(cmd_valid), 32'd1);
    check({tag, " dir"},   32'(cmd_rd_wr_L), 32'(exp_rd));
    check({tag, " qid"},   32'(cmd_qid), 32'(exp_q));
    check({tag, " addr"},  cmd_addr, exp_addr);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    cmd_done  = 1'b1;
    @(negedge clk);
    cmd_done  = 1'b0;
    check({tag, " grant"},  32'(exp_rd ? rd_grant : wr_grant), 32'(mask));
    check({tag, " ngrant"}, 32'(exp_rd ? wr_grant : rd_grant), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; wr_req = '0; rd_req = '0; ctrl = '0;
    cmd_ready = 1'b0; cmd_done = 1'b0;
    for (int j = 0; j < N; j++) begin
      lo[j*AW +: AW] = 32'(j * 1024);
      hi[j*AW +: AW] = 32'(j * 1024 + 1023);
    end
    lo[0 +: AW] = 32'd0;
    hi[0 +: AW] = 32'd3;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst valid", 32'(cmd_valid), 32'd0);
    check("rst addr", cmd_addr, 32'd0);
    check("rst wr_addr0", wr_addr[0 +: AW], 32'd0);
    check("rst rd_addr0", rd_addr[0 +: AW], 32'd0);
    check("rst grants", 32'({wr_grant, rd_grant}), 32'd0);
    check("rst err", 32'(sched_err), 32'd0);

    // q0 window 0..3: fill with four writes, pointer wraps, then stall full
    rst_n = 1'b1;
    ctrl[0 +: AW] = 32'd1;
    wr_req = 8'h01;
    serve("w0", 1'b0, 0, 32'd0);
    serve("w1", 1'b0, 0, 32'd1);
    serve("w2", 1'b0, 0, 32'd2);
    serve("w3", 1'b0, 0, 32'd3);
    check("wrap wr_addr0", wr_addr[0 +: AW], 32'd0);
    check("wrap rd_addr0", rd_addr[0 +: AW], 32'd0);
    repeat (10) @(negedge clk);
    check("full no cmd", 32'(cmd_valid), 32'd0);

    // Read and write both requested: strict alternation starting with a read
    rd_req = 8'h01;
    serve("alt r0", 1'b1, 0, 32'd0);
    serve("alt w0", 1'b0, 0, 32'd0);
    serve("alt r1", 1'b1, 0, 32'd1);
    serve("alt w1", 1'b0, 0, 32'd1);
    serve("alt r2", 1'b1, 0, 32'd2);
    serve("alt w2", 1'b0, 0, 32'd2);
    wr_req = '0; rd_req = '0;
    check("alt rd_addr0", rd_addr[0 +: AW], 32'd3);
    check("alt wr_addr0", wr_addr[0 +: AW], 32'd3);

    // All queues writing with default windows: round-robin starts after pointer 0
    do_reset();
    hi[0 +: AW] = 32'd1023;
    for (int j = 0; j < N; j++) ctrl[j*AW +: AW] = 32'd1;
    wr_req = 8'hFF;
    for (int j = 1; j < N; j++) serve($sformatf("rr q%0d", j), 1'b0, j, 32'(j * 1024));
    serve("rr q0", 1'b0, 0, 32'd0);
    serve("rr q1b", 1'b0, 1, 32'd1025);

    // Backpressure: command held stable; cmd_done during ISSUE ignored
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("hold valid", 32'(cmd_valid), 32'd1);
      check("hold addr", cmd_addr, 32'd2049);
      check("hold qid", 32'(cmd_qid), 32'd2);
      cmd_done = (i == 4);
      @(negedge clk);
    end
    cmd_done = 1'b0;
    check("early done grant", 32'(wr_grant), 32'd0);
    check("early done ptr", wr_addr[2*AW +: AW], 32'd2049);
    serve("hold rel", 1'b0, 2, 32'd2049);
    check("hold rel ptr", wr_addr[2*AW +: AW], 32'd2050);
    wr_req = '0;

    // Flush q2 holding five blocks
    do_reset();
    ctrl = '0;
    ctrl[2*AW +: AW] = 32'd1;
    wr_req = 8'h04;
    for (int k = 0; k < 5; k++) serve($sformatf("fl w%0d", k), 1'b0, 2, 32'(2048 + k));
    check("pre-flush wr_addr2", wr_addr[2*AW +: AW], 32'd2053);
    check("pre-flush rd_addr2", rd_addr[2*AW +: AW], 32'd2048);
    wr_req = '0;
    ctrl[2*AW +: AW] = 32'd3;
    repeat (2) @(negedge clk);
    ctrl[2*AW +: AW] = 32'd1;
    rd_req = 8'h04;
    repeat (10) @(negedge clk);
    check("flush no read", 32'(cmd_valid), 32'd0);
    check("flush rd_addr2", rd_addr[2*AW +: AW], 32'd2048);
    check("flush wr_addr2", wr_addr[2*AW +: AW], 32'd2048);

    // Single-block window on q5
    lo[5*AW +: AW] = 32'd5120;
    hi[5*AW +: AW] = 32'd5120;
    ctrl[5*AW +: AW] = 32'd1;
    wr_req = 8'h20;
    serve("sb w", 1'b0, 5, 32'd5120);
    check("sb wr_addr5", wr_addr[5*AW +: AW], 32'd5120);
    repeat (10) @(negedge clk);
    check("sb full", 32'(cmd_valid), 32'd0);
    rd_req = 8'h24;
    serve("sb r", 1'b1, 5, 32'd5120);
    check("sb rd_addr5", rd_addr[5*AW +: AW], 32'd5120);
    serve("sb w2", 1'b0, 5, 32'd5120);
    wr_req = '0; rd_req = '0;
    check("no err", 32'(sched_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
